// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pipe_adder_pkg
// Purpose  : Shared constants and width/slice helpers for pipe_adder_param.
// Options  : none (PIPE_ADDER_BYPASS_EN is consumed by pipe_adder_param)
// Revision : 1.0 - initial parametrised release
// ============================================================================
package pipe_adder_pkg;

  // Operation select as seen on the sub input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Total operand width for a given segmentation.
  function automatic int calc_data_w(input int seg_w, input int nseg);
    return seg_w * nseg;
  endfunction

  // Lowest bit index of segment idx.
  function automatic int seg_lo(input int idx, input int seg_w);
    return idx * seg_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_adder_param_seg_add_stage.sv
`default_nettype none
// ============================================================================
// Module   : seg_add_stage
// Purpose  : One pipeline stage: resolves segment IDX from the incoming carry,
//            merges it into the travelling partial sum, and registers the
//            carry, valid bit, partial sum and delayed operands.
// Options  : none
// Revision : 1.0 - initial parametrised release
// ============================================================================
module seg_add_stage
  import pipe_adder_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SEG_W  = 8,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              valid_in,
  input  logic              carry_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] sum_in,
  output logic              valid_out,
  output logic              carry_out,
  output logic              ovf_out,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] sum_out
);

  localparam int LO = seg_lo(IDX, SEG_W);
  localparam int HI = LO + SEG_W - 1;
  localparam logic [DATA_W-1:0] SEG_MASK = DATA_W'({SEG_W{1'b1}}) << LO;

  logic [SEG_W:0]    seg_res;
  logic [DATA_W-1:0] sum_next;
  logic              ovf_next;

  // Segment adder: SEG_W-bit sum plus carry out of this slice.
  assign seg_res = {1'b0, a_in[HI:LO]} + {1'b0, b_in[HI:LO]} + {{SEG_W{1'b0}}, carry_in};

  // Lower segments already resolved pass through; this slice is replaced.
  assign sum_next = (sum_in & ~SEG_MASK) | (DATA_W'(seg_res[SEG_W-1:0]) << LO);

  // Carry into the slice MSB is recovered from a^b^s at that bit; only the
  // top stage's flag is meaningful as the signed overflow of the full word.
  assign ovf_next = (a_in[HI] ^ b_in[HI] ^ seg_res[SEG_W-1]) ^ seg_res[SEG_W];

  // Stage register: holds everything while en is low, clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
      carry_out <= 1'b0;
      ovf_out   <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      sum_out   <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      carry_out <= seg_res[SEG_W];
      ovf_out   <= ovf_next;
      a_out     <= a_in;
      b_out     <= b_in;
      sum_out   <= sum_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_adder_param.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder_param
// Purpose  : Pipelined ripple-segment adder/subtractor. NSEG stages of SEG_W
//            bits each; latency NSEG enabled cycles, one op per enabled cycle.
//            Reports raw carry (c) and signed overflow (ovf).
// Options  : PIPE_ADDER_BYPASS_EN - adds a 'bypass' input giving a one-cycle
//            full-width path, accepted only when the pipeline is empty.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module pipe_adder_param
  import pipe_adder_pkg::*;
#(
  parameter  int SEG_W  = 8,
  parameter  int NSEG   = 8,
  localparam int DATA_W = calc_data_w(SEG_W, NSEG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic              sub,
  input  logic              cin,
  input  logic [DATA_W-1:0] data_in_a,
  input  logic [DATA_W-1:0] data_in_b,
`ifdef PIPE_ADDER_BYPASS_EN
  input  logic              bypass,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] sum,
  output logic              c,
  output logic              ovf
);

  // Index 0 is the (combinational) capture point; index k is stage k output.
  logic [DATA_W-1:0] a_pipe   [NSEG+1];
  logic [DATA_W-1:0] b_pipe   [NSEG+1];
  logic [DATA_W-1:0] sum_pipe [NSEG+1];
  logic [NSEG:0]     v_pipe;
  logic [NSEG:0]     carry_pipe;
  logic [NSEG-1:0]   ovf_vec;
  logic              pipe_in_valid;
  logic              unused_tail;

  // Subtraction is a + ~b + ~cin, so B and the carry are conditioned here.
  assign a_pipe[0]     = data_in_a;
  assign b_pipe[0]     = (sub == MODE_SUB) ? ~data_in_b : data_in_b;
  assign carry_pipe[0] = (sub == MODE_ADD) ? cin : ~cin;
  assign sum_pipe[0]   = '0;
  assign v_pipe[0]     = pipe_in_valid;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    seg_add_stage #(
      .DATA_W (DATA_W),
      .SEG_W  (SEG_W),
      .IDX    (k)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .valid_in  (v_pipe[k]),
      .carry_in  (carry_pipe[k]),
      .a_in      (a_pipe[k]),
      .b_in      (b_pipe[k]),
      .sum_in    (sum_pipe[k]),
      .valid_out (v_pipe[k+1]),
      .carry_out (carry_pipe[k+1]),
      .ovf_out   (ovf_vec[k]),
      .a_out     (a_pipe[k+1]),
      .b_out     (b_pipe[k+1]),
      .sum_out   (sum_pipe[k+1])
    );
  end

  // Operands leaving the last stage and intermediate overflow flags have
  // no consumer; they are folded into a single sink.
  assign unused_tail = ^{a_pipe[NSEG], b_pipe[NSEG], ovf_vec};

`ifdef PIPE_ADDER_BYPASS_EN
  logic              any_inflight;
  logic [DATA_W:0]   byp_full;
  logic              byp_ovf_next;
  logic              byp_valid;
  logic [DATA_W-1:0] byp_sum;
  logic              byp_c;
  logic              byp_ovf;

  assign pipe_in_valid = in_valid & ~bypass;
  assign any_inflight  = |v_pipe[NSEG:1];
  assign byp_full      = {1'b0, a_pipe[0]} + {1'b0, b_pipe[0]} + {{DATA_W{1'b0}}, carry_pipe[0]};
  assign byp_ovf_next  = a_pipe[0][DATA_W-1] ^ b_pipe[0][DATA_W-1] ^ byp_full[DATA_W-1] ^ byp_full[DATA_W];

  // Single-cycle bypass register; refused while pipelined work is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp_valid <= 1'b0;
      byp_sum   <= '0;
      byp_c     <= 1'b0;
      byp_ovf   <= 1'b0;
    end else if (en) begin
      byp_valid <= in_valid & bypass & ~any_inflight;
      byp_sum   <= byp_full[DATA_W-1:0];
      byp_c     <= byp_full[DATA_W];
      byp_ovf   <= byp_ovf_next;
    end
  end

  // Flags a bypass request that collides with in-flight pipelined ops.
  always @(posedge clk) begin
    if (reset_n && en && in_valid && bypass) begin
      assert (!any_inflight);
    end
  end

  assign out_valid = byp_valid | v_pipe[NSEG];
  assign sum       = byp_valid ? byp_sum : sum_pipe[NSEG];
  assign c         = byp_valid ? byp_c   : carry_pipe[NSEG];
  assign ovf       = byp_valid ? byp_ovf : ovf_vec[NSEG-1];
`else
  assign pipe_in_valid = in_valid;
  assign out_valid     = v_pipe[NSEG];
  assign sum           = sum_pipe[NSEG];
  assign c             = carry_pipe[NSEG];
  assign ovf           = ovf_vec[NSEG-1];
`endif

endmodule
`default_nettype wire
